// File: rtl/greedy_snake_dpb_r.sv
// Greedy Snake body list reader on Gowin_DPB channel B: walks the node list and streams positions.
// Optional compare logic (hit / self_hit) is built when GREEDY_SNAKE_RD_HIT_EN is defined.
module greedy_snake_dpb_r #(
    parameter int unsigned RD_LATENCY = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [10:0] list_head_addr,
    input  logic [10:0] list_length,
    input  logic [7:0]  cmp_pos,
    output logic        busy,
    output logic        done,
    output logic        err,
    output logic        pos_valid,
    input  logic        pos_ready,
    output logic [7:0]  pos_data,
    output logic [10:0] pos_index,
    output logic        pos_last,
    output logic        hit,
    output logic        self_hit,
    output logic        i_b_clk_en,
    output logic        i_b_data_en,
    output logic        i_b_wr_en,
    output logic [10:0] i_b_address,
    input  logic [7:0]  o_b_data
);
    typedef enum logic [2:0] {StIdle, StFetch, StWait, StOut, StDone} state_e;

    localparam logic [1:0] TagNone = 2'd0;
    localparam logic [1:0] TagPos  = 2'd1;
    localparam logic [1:0] TagHi   = 2'd2;
    localparam logic [1:0] TagLo   = 2'd3;
    localparam int unsigned TagW   = 2 * (RD_LATENCY + 1);

    state_e      state_q;
    logic [10:0] cur_q, idx_q, len_q, nxt_q, addr_q;
    logic [1:0]  fcnt_q;
    logic [TagW-1:0] tag_q;
    logic [7:0]  pos_q, pos_data_q;
    logic [2:0]  nxt_hi_q;
    logic [10:0] pos_index_q;
    logic        busy_q, done_q, err_q, pos_valid_q, pos_last_q, clk_en_q;
    logic        hit_q, self_hit_q;
    logic [1:0]  tag_out;
    logic [10:0] nxt_full;

    // Each issued address carries a tag that emerges exactly when its byte is on o_b_data.
    assign tag_out  = tag_q[TagW-1 -: 2];
    assign nxt_full = {nxt_hi_q, o_b_data};

`ifdef GREEDY_SNAKE_RD_HIT_EN
    logic [7:0] cmp_q, head_pos_q;
`else
    logic unused_cmp;
    assign unused_cmp = ^cmp_pos;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= StIdle;
            cur_q       <= '0;
            idx_q       <= '0;
            len_q       <= '0;
            nxt_q       <= '0;
            addr_q      <= '0;
            fcnt_q      <= '0;
            tag_q       <= '0;
            pos_q       <= '0;
            nxt_hi_q    <= '0;
            pos_data_q  <= '0;
            pos_index_q <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
            pos_valid_q <= 1'b0;
            pos_last_q  <= 1'b0;
            clk_en_q    <= 1'b0;
            hit_q       <= 1'b0;
            self_hit_q  <= 1'b0;
`ifdef GREEDY_SNAKE_RD_HIT_EN
            cmp_q       <= '0;
            head_pos_q  <= '0;
`endif
        end else begin
            clk_en_q <= 1'b1;
            done_q   <= 1'b0;
            tag_q    <= {tag_q[TagW-3:0], TagNone};

            if (tag_out == TagPos) pos_q <= o_b_data;
            if (tag_out == TagHi)  nxt_hi_q <= o_b_data[2:0];

            unique case (state_q)
                StIdle: begin
                    if (start) begin
                        len_q      <= list_length;
                        idx_q      <= '0;
                        cur_q      <= list_head_addr;
                        err_q      <= 1'b0;
                        hit_q      <= 1'b0;
                        self_hit_q <= 1'b0;
`ifdef GREEDY_SNAKE_RD_HIT_EN
                        cmp_q      <= cmp_pos;
`endif
                        if (list_length == 11'd0) begin
                            done_q <= 1'b1;
                        end else begin
                            busy_q     <= 1'b1;
                            addr_q     <= list_head_addr;
                            tag_q[1:0] <= TagPos;
                            fcnt_q     <= 2'd1;
                            state_q    <= StFetch;
                        end
                    end
                end
                StFetch: begin
                    if (fcnt_q == 2'd1) begin
                        addr_q     <= cur_q + 11'd2;
                        tag_q[1:0] <= TagHi;
                        fcnt_q     <= 2'd2;
                    end else begin
                        addr_q     <= cur_q + 11'd3;
                        tag_q[1:0] <= TagLo;
                        state_q    <= StWait;
                    end
                end
                StWait: begin
                    addr_q <= '0;
                    if (tag_out == TagLo) begin
                        nxt_q       <= nxt_full;
                        pos_valid_q <= 1'b1;
                        pos_data_q  <= pos_q;
                        pos_index_q <= idx_q;
                        pos_last_q  <= (idx_q == len_q - 11'd1) || (nxt_full == 11'd0);
`ifdef GREEDY_SNAKE_RD_HIT_EN
                        if (idx_q == 11'd0) head_pos_q <= pos_q;
`endif
                        state_q     <= StOut;
                    end
                end
                StOut: begin
                    if (pos_ready) begin
                        pos_valid_q <= 1'b0;
`ifdef GREEDY_SNAKE_RD_HIT_EN
                        if (pos_data_q == cmp_q) hit_q <= 1'b1;
                        if (idx_q != 11'd0 && pos_data_q == head_pos_q) self_hit_q <= 1'b1;
`endif
                        if (pos_last_q) begin
                            err_q   <= (nxt_q == 11'd0) && (idx_q < len_q - 11'd1);
                            state_q <= StDone;
                        end else begin
                            cur_q      <= nxt_q;
                            idx_q      <= idx_q + 11'd1;
                            addr_q     <= nxt_q;
                            tag_q[1:0] <= TagPos;
                            fcnt_q     <= 2'd1;
                            state_q    <= StFetch;
                        end
                    end
                end
                StDone: begin
                    done_q  <= 1'b1;
                    busy_q  <= 1'b0;
                    state_q <= StIdle;
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign busy        = busy_q;
    assign done        = done_q;
    assign err         = err_q;
    assign pos_valid   = pos_valid_q;
    assign pos_data    = pos_data_q;
    assign pos_index   = pos_index_q;
    assign pos_last    = pos_last_q;
    assign hit         = hit_q;
    assign self_hit    = self_hit_q;
    assign i_b_clk_en  = clk_en_q;
    assign i_b_data_en = clk_en_q;
    assign i_b_wr_en   = 1'b0;
    assign i_b_address = addr_q;

endmodule

// File: tb/tb_greedy_snake_dpb_r.sv
// Bench for greedy_snake_dpb_r: DPB read model, table of walks, scoreboard of expected nodes.
module tb_greedy_snake_dpb_r;
    logic        clk = 1'b0;
    logic        rst, start, pos_ready;
    logic [10:0] list_head_addr, list_length;
    logic [7:0]  cmp_pos;
    logic        busy, done, err, pos_valid, pos_last, hit, self_hit;
    logic        i_b_clk_en, i_b_data_en, i_b_wr_en;
    logic [7:0]  pos_data, o_b_data;
    logic [10:0] pos_index, i_b_address;

    always #5 clk = ~clk;

    greedy_snake_dpb_r dut (
        .clk            (clk),
        .rst            (rst),
        .start          (start),
        .list_head_addr (list_head_addr),
        .list_length    (list_length),
        .cmp_pos        (cmp_pos),
        .busy           (busy),
        .done           (done),
        .err            (err),
        .pos_valid      (pos_valid),
        .pos_ready      (pos_ready),
        .pos_data       (pos_data),
        .pos_index      (pos_index),
        .pos_last       (pos_last),
        .hit            (hit),
        .self_hit       (self_hit),
        .i_b_clk_en     (i_b_clk_en),
        .i_b_data_en    (i_b_data_en),
        .i_b_wr_en      (i_b_wr_en),
        .i_b_address    (i_b_address),
        .o_b_data       (o_b_data)
    );

    // DPB with output register: two cycles from address to data.
    logic [7:0]  mem [2048];
    logic [10:0] a1;
    always @(posedge clk) begin
        a1       <= i_b_address;
        o_b_data <= mem[a1];
    end

    typedef struct {
        logic [10:0] head;
        logic [10:0] len;
        logic [7:0]  cmp;
        int          stall_idx;
        int          stall_n;
        bit          poke;
    } case_t;

    typedef struct {
        logic [7:0]  data;
        logic [10:0] idx;
        logic        last;
    } exp_t;

    exp_t  q[$];
    int    checks = 0;
    int    errors = 0;
    case_t tbl [6];

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
        end
    endtask

    task automatic build_exp(input case_t c, output bit e_err, output bit e_hit,
                             output bit e_self, output int n);
        logic [10:0] cur, nxt, a2, a3;
        logic [7:0]  hp, p, hi;
        logic        l;
        q.delete();
        e_err = 0; e_hit = 0; e_self = 0; n = 0;
        cur = c.head; hp = '0;
        for (int i = 0; i < int'(c.len); i++) begin
            a2  = cur + 11'd2;
            a3  = cur + 11'd3;
            p   = mem[cur];
            hi  = mem[a2];
            nxt = {hi[2:0], mem[a3]};
            l   = (i == int'(c.len) - 1) || (nxt == 11'd0);
            if (i == 0) hp = p;
            if (p == c.cmp) e_hit = 1;
            if (i > 0 && p == hp) e_self = 1;
            q.push_back('{data: p, idx: 11'(i), last: l});
            n++;
            if (l) begin
                e_err = (nxt == 11'd0) && (i < int'(c.len) - 1);
                break;
            end
            cur = nxt;
        end
`ifndef GREEDY_SNAKE_RD_HIT_EN
        e_hit  = 0;
        e_self = 0;
`endif
    endtask

    task automatic run_case(input case_t c);
        bit   e_err, e_hit, e_self, seen_done;
        int   n, cyc, first_v, stall_left, got;
        exp_t e;
        build_exp(c, e_err, e_hit, e_self, n);
        list_head_addr = c.head;
        list_length    = c.len;
        cmp_pos        = c.cmp;
        pos_ready      = 1'b1;
        start          = 1'b1;
        stall_left = c.stall_n; first_v = -1; got = 0; seen_done = 0; cyc = 0;
        while (!seen_done && cyc < 200) begin
            @(negedge clk);
            cyc++;
            start = c.poke && cyc == 3;
            if (c.poke && cyc == 3) list_head_addr = 11'd2046;
            if (cyc == 1) chk("busy_after_start", busy, int'(c.len != 11'd0));
            pos_ready = 1'b1;
            if (pos_valid) begin
                if (first_v < 0) first_v = cyc;
                if (q.size() == 0) begin
                    chk("node_count_extra", got + 1, n);
                end else if (stall_left > 0 && int'(q[0].idx) == c.stall_idx) begin
                    pos_ready = 1'b0;
                    stall_left--;
                    chk("stall_data", pos_data, q[0].data);
                    chk("stall_index", pos_index, q[0].idx);
                end else begin
                    e = q.pop_front();
                    got++;
                    chk("pos_data", pos_data, e.data);
                    chk("pos_index", pos_index, e.idx);
                    chk("pos_last", pos_last, e.last);
                end
            end
            if (done) begin
                seen_done = 1;
                chk("err", err, e_err);
                chk("hit", hit, e_hit);
                chk("self_hit", self_hit, e_self);
                chk("busy_at_done", busy, 0);
                chk("node_count", got, n);
                chk("done_cycle", cyc, (c.len == 11'd0) ? 1 : n * 6 + 2 + c.stall_n);
                if (n > 0) chk("first_valid_cycle", first_v, 6);
            end
        end
        chk("done_seen", int'(seen_done), 1);
        start     = 1'b0;
        pos_ready = 1'b1;
        @(negedge clk);
        chk("done_one_cycle", done, 0);
        chk("idle_busy", busy, 0);
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_done"}, done, 0);
        chk({tag, "_err"}, err, 0);
        chk({tag, "_pos_valid"}, pos_valid, 0);
        chk({tag, "_pos_last"}, pos_last, 0);
        chk({tag, "_hit"}, hit, 0);
        chk({tag, "_self_hit"}, self_hit, 0);
        chk({tag, "_pos_data"}, pos_data, 0);
        chk({tag, "_pos_index"}, pos_index, 0);
        chk({tag, "_addr"}, i_b_address, 0);
        chk({tag, "_clk_en"}, i_b_clk_en, 0);
        chk({tag, "_data_en"}, i_b_data_en, 0);
        chk({tag, "_wr_en"}, i_b_wr_en, 0);
    endtask

    initial begin
        bit bad;
        for (int i = 0; i < 2048; i++) mem[i] = 8'h00;
        mem[4]  = 8'h44; mem[6]  = 8'h00; mem[7]  = 8'h08;
        mem[8]  = 8'h34; mem[10] = 8'h00; mem[11] = 8'h0C;
        mem[12] = 8'h24; mem[14] = 8'h00; mem[15] = 8'h00;
        // Wrapping node: bytes at 2046, 2047, 0, 1; upper bits of next-hi must be ignored.
        mem[2046] = 8'h55; mem[0] = 8'hF8; mem[1] = 8'h10;
        mem[16]   = 8'h66; mem[18] = 8'hF8; mem[19] = 8'h00;

        tbl[0] = '{head: 11'd4,    len: 11'd3, cmp: 8'h34, stall_idx: -1, stall_n: 0, poke: 1'b1};
        tbl[1] = '{head: 11'd4,    len: 11'd5, cmp: 8'h99, stall_idx: -1, stall_n: 0, poke: 1'b0};
        tbl[2] = '{head: 11'd4,    len: 11'd3, cmp: 8'h24, stall_idx: 1,  stall_n: 7, poke: 1'b0};
        tbl[3] = '{head: 11'd4,    len: 11'd0, cmp: 8'h44, stall_idx: -1, stall_n: 0, poke: 1'b0};
        tbl[4] = '{head: 11'd4,    len: 11'd2, cmp: 8'h44, stall_idx: -1, stall_n: 0, poke: 1'b0};
        tbl[5] = '{head: 11'd2046, len: 11'd2, cmp: 8'h66, stall_idx: -1, stall_n: 0, poke: 1'b0};

        rst = 1'b1; start = 1'b0; pos_ready = 1'b1;
        list_head_addr = '0; list_length = '0; cmp_pos = '0;
        repeat (3) @(negedge clk);
        chk_reset_vals("reset");
        rst = 1'b0;
        @(negedge clk);
        chk("clk_en_after_reset", i_b_clk_en, 1);
        chk("data_en_after_reset", i_b_data_en, 1);

        for (int k = 0; k < 6; k++) run_case(tbl[k]);

        // Reset during WAIT of idx 1 aborts without a done pulse.
        list_head_addr = 11'd4; list_length = 11'd3; cmp_pos = 8'h34; start = 1'b1;
        for (int cyc = 1; cyc <= 10; cyc++) begin
            @(negedge clk);
            start = 1'b0;
        end
        chk("busy_before_abort", busy, 1);
        rst = 1'b1;
        @(negedge clk);
        chk_reset_vals("abort");
        rst = 1'b0;
        bad = 0;
        for (int cyc = 0; cyc < 30; cyc++) begin
            @(negedge clk);
            if (done || pos_valid || busy) bad = 1;
        end
        chk("no_activity_after_abort", int'(bad), 0);
        run_case(tbl[0]);

        // Tail repeating the head position.
        mem[12] = 8'h44;
        run_case(tbl[0]);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/greedy_snake_dpb_r.md
# greedy_snake_dpb_r

Linked-list reader for the Greedy Snake body stored in Gowin_DPB. It runs on DPB channel B, opposite the channel-A list writer. On a start pulse it walks the list from the writer's head address for the writer's list length and streams one body position per node over a valid/ready port, for the renderer and collision logic. Node format is 4 bytes at node address n:
- n+0: position {x[3:0], y[3:0]}
- n+1: reserved
- n+2: next[10:8] in bits [2:0]
- n+3: next[7:0]

Next address 0 is NULL.

## Interface
- RD_LATENCY, 2: cycles from an address appearing on i_b_address to its byte being valid on o_b_data (DPB output register enabled).
- clk  in  1  single clock.
- rst  in  1  synchronous, active-high reset.
- start  in  1  one-cycle walk request; accepted only while busy=0.
- list_head_addr  in  11  head node address; sampled on an accepted start.
- list_length  in  11  node count; sampled on an accepted start.
- cmp_pos  in  8  query position; sampled on an accepted start (hit feature only).
- busy  out  1  high from the cycle after an accepted start until done.
- done  out  1  one-cycle pulse at the end of a walk.
- err  out  1  valid while done=1: the list ended on NULL before list_length nodes.
- pos_valid  out  1  stream valid.
- pos_ready  in  1  stream ready.
- pos_data  out  8  node position.
- pos_index  out  11  node ordinal; 0 = head.
- pos_last  out  1  final node of the walk.
- hit  out  1  valid while done=1: some emitted pos_data equalled cmp_pos.
- self_hit  out  1  valid while done=1: some node with index≥1 equalled the head position.
- i_b_clk_en, i_b_data_en  out  1  held 1 (0 only during reset).
- i_b_wr_en  out  1  held 0.
- i_b_address  out  11  registered read address.
- o_b_data  in  8  DPB read data.

## Operation
- Reset values:
  - busy, done, err, pos_valid, pos_last, hit, self_hit, i_b_wr_en, i_b_clk_en, i_b_data_en = 0.
  - pos_data = 0, pos_index = 0, i_b_address = 0.
  - State = IDLE.
  - i_b_clk_en and i_b_data_en go to 1 on the first cycle after reset.
- **IDLE**
  - On start: snapshot head, length and cmp_pos; set cur=head and idx=0.
  - If length=0: go to DONE with err=0.
  - Otherwise go to FETCH.
- **FETCH** (3 cycles)
  - Drive i_b_address = cur, cur+2, cur+3 on consecutive cycles.
  - After the third address, i_b_address returns to 0.
- **WAIT**
  - Capture the byte for each issued address exactly RD_LATENCY cycles after that address appeared: pos, nxt_hi, nxt_lo.
  - nxt = {nxt_hi[2:0], nxt_lo}; upper bits of nxt_hi are ignored.
  - 11-bit address arithmetic wraps modulo 2048.
- **OUT**
  - Assert pos_valid with pos_data=pos, pos_index=idx, and pos_last = (idx==length-1) or (nxt==0).
  - Hold all stream outputs stable until pos_valid && pos_ready.
- **On handshake:**
  - If pos_last: set err = (nxt==0 && idx<length-1), then go to DONE.
  - Otherwise: cur=nxt, idx=idx+1, go to FETCH.
  - The final node's next pointer is not checked (non-NULL tail is not an error).
- **DONE**
  - One cycle: done=1, busy=0, err/hit/self_hit valid.
  - Next state is IDLE.
  - err/hit/self_hit hold until the next accepted start clears them.
- start while busy is ignored; no queuing.
- rst mid-walk aborts immediately, outputs return to reset values, and no done pulse is produced.
- The reader never writes the DPB. Coherence with concurrent channel-A writes is the system's responsibility: walks are started only while the writer's busy=0.

## Timing
- Start accepted at edge T → busy=1 and first address on i_b_address from T+1.
- With pos_ready held high, node period = RD_LATENCY+4 cycles:
  - 3 cycles FETCH;
  - RD_LATENCY cycles until the last byte is captured;
  - 1 cycle OUT.
- First pos_valid = T+1+RD_LATENCY+3.
- Stalled pos_ready adds cycles 1:1.
- done rises the cycle after the final handshake.
- Per-walk latency, N nodes, ready high: N·(RD_LATENCY+4)+2 cycles from start to done.
- length=0: done asserted at T+1.

## Configuration
- **GREEDY_SNAKE_RD_HIT_EN defined:**
  - Compare logic is built.
  - hit accumulates (pos==cmp_pos) over emitted nodes.
  - self_hit accumulates (pos==head position captured at idx 0) for idx≥1.
  - Both are cleared on start.
- **Undefined:** hit and self_hit are tied 0, cmp_pos is unused, and no compare registers are built.

## Test plan
- List as built by a writer reset: node 4 = {44,00,00,08}, node 8 = {34,00,00,0C}, node 12 = {24,00,00,00}; head=4, len=3, ready=1 → stream 0x44/0, 0x34/1, 0x24/2 with pos_last on idx 2; err=0; first pos_valid at T+6; done at T+20.
- Same list with len=5 → 3 nodes emitted, pos_last on idx 2, done with err=1.
- Backpressure: ready low for 7 cycles on idx 1 → pos_data=0x34 and pos_index=1 stay stable while stalled; totals shift by +7.
- len=0 → no pos_valid, done at T+1, err=0; a start pulsed while busy=1 is ignored.
- rst asserted during WAIT of idx 1 → all outputs return to reset values next cycle, no done; a fresh start completes normally.
- HIT_EN, cmp_pos=0x34 → hit=1, self_hit=0. Patching node 12 byte0 to 0x44 → self_hit=1. With the macro off → hit=self_hit=0.
